// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: opcode constants, operand-B source encoding and decode helpers
package hazard_ctrl_pkg;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    OPB_RS2  = 2'd0,
    OPB_IMM  = 2'd1,
    OPB_LINK = 2'd2
  } opb_src_e;

  function automatic logic uses_rs1(input logic [6:0] op);
    return op == OPC_OP || op == OPC_OP_IMM || op == OPC_LOAD || op == OPC_STORE || op == OPC_BRANCH;
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return op == OPC_OP || op == OPC_STORE || op == OPC_BRANCH;
  endfunction

  function automatic logic writes_rd(input logic [6:0] op);
    return op == OPC_OP || op == OPC_OP_IMM || op == OPC_LOAD || op == OPC_LUI || op == OPC_JAL;
  endfunction

  function automatic opb_src_e opb_of(input logic [6:0] op);
    return op == OPC_JAL ? OPB_LINK :
           (op == OPC_OP_IMM || op == OPC_LUI || op == OPC_LOAD || op == OPC_STORE) ? OPB_IMM : OPB_RS2;
  endfunction
endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: shift register of in-flight destinations with two youngest-match lookups
module hazard_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 2,
  parameter int SEL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              arstn,
  input  logic              en,
  input  logic              push_valid,
  input  logic [REG_AW-1:0] push_rd,
  input  logic              push_load,
  input  logic              qa_en,
  input  logic [REG_AW-1:0] qa_addr,
  input  logic              qb_en,
  input  logic [REG_AW-1:0] qb_addr,
  output logic [SEL_W-1:0]  sel_a,
  output logic              ld_a,
  output logic [SEL_W-1:0]  sel_b,
  output logic              ld_b
);
  logic [DEPTH-1:0]             vld_q, vld_d, isld_q, isld_d;
  logic [DEPTH-1:0][REG_AW-1:0] rd_q, rd_d;

  // Returns {is_load, select} of the youngest valid entry matching addr; select 0 means no match.
  function automatic logic [SEL_W:0] lookup(input logic q_en, input logic [REG_AW-1:0] addr);
    logic [SEL_W:0] r;
    r = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (q_en && vld_q[i] && rd_q[i] == addr) r = {isld_q[i], SEL_W'(i + 1)};
    return r;
  endfunction

  // Next scoreboard state: shift older and insert the new entry when the pipeline advances.
  always_comb begin
    vld_d  = vld_q;
    rd_d   = rd_q;
    isld_d = isld_q;
    if (en) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        vld_d[i]  = vld_q[i-1];
        rd_d[i]   = rd_q[i-1];
        isld_d[i] = isld_q[i-1];
      end
      vld_d[0]  = push_valid;
      rd_d[0]   = push_rd;
      isld_d[0] = push_load;
    end
  end

  // Scoreboard registers; reset empties every entry.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      vld_q  <= '0;
      rd_q   <= '0;
      isld_q <= '0;
    end else begin
      vld_q  <= vld_d;
      rd_q   <= rd_d;
      isld_q <= isld_d;
    end
  end

  // Two independent source lookups.
  always_comb begin
    {ld_a, sel_a} = lookup(qa_en, qa_addr);
    {ld_b, sel_b} = lookup(qb_en, qb_addr);
  end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding select, load-use stall, operand-B decode and stall counting
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             en,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  output logic [SEL_W-1:0] fwd_sel_a,
  output logic [SEL_W-1:0] fwd_sel_b,
  output logic [1:0]       opb_src,
  output logic             jal_redirect,
  output logic             stall,
  output logic [31:0]      stall_cnt
);
  logic [6:0]        op;
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic              live, use_a, use_b, push_valid;
  logic [SEL_W-1:0]  sel_a, sel_b;
  logic              ld_a, ld_b;
  logic [31:0]       stall_cnt_q, stall_cnt_d;
  logic              unused_bits;

  assign op          = id_instr[6:0];
  assign rd          = id_instr[7 +: REG_AW];
  assign rs1         = id_instr[15 +: REG_AW];
  assign rs2         = id_instr[20 +: REG_AW];
  assign unused_bits = ^{id_instr[31:25], id_instr[14:12]};

  // Source qualification, hazard detection and output decode; a squashed or empty slot drives zeros.
  always_comb begin
    live         = id_valid && !flush;
    use_a        = live && uses_rs1(op) && rs1 != '0;
    use_b        = live && uses_rs2(op) && rs2 != '0;
    stall        = (ld_a && sel_a != '0 && int'(sel_a) <= LOAD_LAT) ||
                   (ld_b && sel_b != '0 && int'(sel_b) <= LOAD_LAT);
    fwd_sel_a    = stall ? '0 : sel_a;
    fwd_sel_b    = stall ? '0 : sel_b;
    opb_src      = live ? opb_of(op) : OPB_RS2;
    jal_redirect = live && !stall && op == OPC_JAL;
    push_valid   = live && !stall && writes_rd(op) && rd != '0;
    stall_cnt_d  = (en && stall && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

  hazard_scoreboard #(.REG_AW(REG_AW), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_sb (
    .clk        (clk),
    .arstn      (arstn),
    .en         (en),
    .push_valid (push_valid),
    .push_rd    (rd),
    .push_load  (op == OPC_LOAD),
    .qa_en      (use_a),
    .qa_addr    (rs1),
    .qb_en      (use_b),
    .qb_addr    (rs2),
    .sel_a      (sel_a),
    .ld_a       (ld_a),
    .sel_b      (sel_b),
    .ld_b       (ld_b)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;
  logic        clk = 0, arstn = 0, en = 1, flush = 0, id_valid = 0;
  logic [31:0] id_instr = '0;
  logic [1:0]  fwd_sel_a, fwd_sel_b, opb_src;
  logic        jal_redirect, stall;
  logic [31:0] stall_cnt;
  int          n_vec = 0, n_bad = 0;

  typedef struct packed {
    logic [1:0]  sa, sb, opb;
    logic        jal, stl;
    logic [31:0] cnt;
  } exp_t;
  exp_t exp_q[$];

  hazard_ctrl dut (
    .clk(clk), .arstn(arstn), .en(en), .flush(flush), .id_valid(id_valid), .id_instr(id_instr),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .opb_src(opb_src),
    .jal_redirect(jal_redirect), .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] r_add(input logic [4:0] rd, rs1, rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] i_addi(input logic [4:0] rd, rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] i_lw(input logic [4:0] rd, rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic exp_t mk(input logic [1:0] sa, sb, opb, input logic jal, stl, input logic [31:0] cnt);
    return '{sa: sa, sb: sb, opb: opb, jal: jal, stl: stl, cnt: cnt};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic compare_now(input string tag);
    exp_t x;
    if (exp_q.size() == 0) begin
      check({tag, ".queue"}, 32'd0, 32'd1);
      return;
    end
    x = exp_q.pop_front();
    check({tag, ".sel_a"}, 32'(fwd_sel_a), 32'(x.sa));
    check({tag, ".sel_b"}, 32'(fwd_sel_b), 32'(x.sb));
    check({tag, ".opb"},   32'(opb_src),   32'(x.opb));
    check({tag, ".jal"},   32'(jal_redirect), 32'(x.jal));
    check({tag, ".stall"}, 32'(stall),     32'(x.stl));
    check({tag, ".cnt"},   stall_cnt,      x.cnt);
  endtask

  task automatic step(input string tag, input logic v, f, e, input logic [31:0] ins, input exp_t x);
    id_valid = v; flush = f; en = e; id_instr = ins;
    exp_q.push_back(x);
    @(negedge clk);
    compare_now(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    step("rst_add", 1, 0, 1, r_add(6, 5, 3), mk(0, 0, 0, 0, 0, 0));
    step("rst_lui", 1, 0, 1, {20'd1, 5'd4, 7'b0110111}, mk(0, 0, 1, 0, 0, 0));
    arstn = 1;
    @(posedge clk); #1;
    step("b2b_p",   1, 0, 1, r_add(5, 1, 2),  mk(0, 0, 0, 0, 0, 0));
    step("b2b_c",   1, 0, 1, r_add(6, 5, 3),  mk(1, 0, 0, 0, 0, 0));
    step("d2_p",    1, 0, 1, i_addi(11, 0, 5), mk(0, 0, 1, 0, 0, 0));
    step("d2_mid",  1, 0, 1, i_addi(12, 0, 1), mk(0, 0, 1, 0, 0, 0));
    step("d2_c",    1, 0, 1, r_add(13, 11, 0), mk(2, 0, 0, 0, 0, 0));
    step("d3_c",    1, 0, 1, r_add(14, 11, 0), mk(0, 0, 0, 0, 0, 0));
    step("lu_ld",   1, 0, 1, i_lw(7, 1),       mk(0, 0, 1, 0, 0, 0));
    step("lu_stl",  1, 0, 1, r_add(8, 7, 7),   mk(0, 0, 0, 0, 1, 0));
    step("lu_rtry", 1, 0, 1, r_add(8, 7, 7),   mk(2, 2, 0, 0, 0, 1));
    step("x0_addi", 1, 0, 1, i_addi(0, 0, 1),  mk(0, 0, 1, 0, 0, 1));
    step("x0_add",  1, 0, 1, r_add(9, 0, 0),   mk(0, 0, 0, 0, 0, 1));
    step("lui",     1, 0, 1, {20'd1, 5'd4, 7'b0110111}, mk(0, 0, 1, 0, 0, 1));
    step("jal",     1, 0, 1, 32'h008000EF,     mk(0, 0, 2, 1, 0, 1));
    step("jal_fl",  1, 1, 1, 32'h008000EF,     mk(0, 0, 0, 0, 0, 1));
    step("jal_inv", 0, 0, 1, 32'h008000EF,     mk(0, 0, 0, 0, 0, 1));
    step("fl_ld",   1, 0, 1, i_lw(7, 1),       mk(0, 0, 1, 0, 0, 1));
    step("fl_haz",  1, 1, 1, r_add(8, 7, 7),   mk(0, 0, 0, 0, 0, 1));
    step("fl_bub",  1, 0, 1, r_add(9, 8, 7),   mk(0, 2, 0, 0, 0, 1));
    step("en_ld",   1, 0, 1, i_lw(7, 1),       mk(0, 0, 1, 0, 0, 1));
    step("en0_a",   1, 0, 0, r_add(8, 7, 7),   mk(0, 0, 0, 0, 1, 1));
    step("en0_b",   1, 0, 0, r_add(8, 7, 7),   mk(0, 0, 0, 0, 1, 1));
    step("en1_stl", 1, 0, 1, r_add(8, 7, 7),   mk(0, 0, 0, 0, 1, 1));
    step("en1_fwd", 1, 0, 1, r_add(8, 7, 7),   mk(2, 2, 0, 0, 0, 2));
    step("rs_ld",   1, 0, 1, i_lw(7, 1),       mk(0, 0, 1, 0, 0, 2));
    id_valid = 1; flush = 0; en = 1; id_instr = r_add(8, 7, 7);
    exp_q.push_back(mk(0, 0, 0, 0, 1, 2));
    @(negedge clk);
    compare_now("rs_stl");
    arstn = 0;
    #1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    compare_now("rs_async");
    @(posedge clk); #1;
    arstn = 1;
    step("rs_after", 1, 0, 1, r_add(8, 7, 7),  mk(0, 0, 0, 0, 0, 0));
    step("rs_after2", 1, 0, 1, r_add(9, 8, 0), mk(1, 0, 0, 0, 0, 0));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
